onehot_to_priority_pipe: RTL and testbench

//  Inverse of the priority-to-one-hot tree. Expands a one-hot (or zero) vector into the

---
 rtl/onehot_to_priority_pipe.sv | 170 +++++++++++++++++
 tb/tb_onehot_to_priority_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_to_priority_pipe.sv
// One-hot to LSB-priority (thermometer) expander, built as a SPLIT-ary tree.
// Each tree level is one pipeline stage with valid/ready flow control.
// The leaf level is the general branch rule applied to 1-bit sub-slices:
// a single bit is its own thermometer and its own valid.
module onehot_to_priority_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SPLIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] dec_oht,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] dec_vld,
  output logic             enc_vld,
  output logic             enc_err
);

  // Number of tree levels: smallest L with SPLIT**L >= w.
  function automatic int unsigned calc_levels(input int unsigned w, input int unsigned s);
    int unsigned l;
    int unsigned p;
    l = 0;
    p = 1;
    for (int i = 0; i < 32; i++) begin
      if (p < w) begin
        p = p * s;
        l = l + 1;
      end
    end
    return l;
  endfunction

  // Integer power for tree-geometry constants.
  function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < e; i++) begin
      r = r * b;
    end
    return r;
  endfunction

  localparam int unsigned LEVELS = calc_levels(WIDTH, SPLIT);
  localparam int unsigned POWER  = ipow(SPLIT, LEVELS);
  localparam int unsigned IW     = (POWER > 2) ? $clog2(POWER) : 1;

  // Reject illegal configurations at elaboration.
  if (SPLIT < 2 || (SPLIT & (SPLIT - 1)) != 0) begin : g_bad_split
    $error("onehot_to_priority_pipe: SPLIT must be a power of 2 (got %0d)", SPLIT);
  end
  if (WIDTH < 2) begin : g_bad_width
    $error("onehot_to_priority_pipe: WIDTH must be >= 2 (got %0d)", WIDTH);
  end

  // src_thr[L]/src_err[L] are the inputs seen by tree level L. Error flags are
  // replicated across each node's slice so a node's flag is the OR of its slice.
  logic [POWER-1:0]  src_thr [LEVELS];
  logic [POWER-1:0]  src_err [LEVELS];
  logic [LEVELS-1:0] stage_vld;
  logic [LEVELS-1:0] stage_ld;

  assign src_thr[0] = POWER'(dec_oht);
  assign src_err[0] = '0;

  // Load enables ripple back from the output; a stage loads when empty or draining.
  always_comb begin
    stage_ld = '0;
    for (int l = int'(LEVELS) - 1; l >= 0; l--) begin
      if (l == int'(LEVELS) - 1) begin
        stage_ld[l] = !stage_vld[l] || out_rdy;
      end else begin
        stage_ld[l] = !stage_vld[l] || stage_ld[l+1];
      end
    end
  end

  assign in_rdy  = stage_ld[0];
  assign out_vld = stage_vld[LEVELS-1];

  for (genvar gl = 0; gl < int'(LEVELS); gl++) begin : g_lvl
    localparam int unsigned SS = ipow(SPLIT, 32'(gl));
    localparam int unsigned NS = SS * SPLIT;
    localparam int unsigned NN = POWER / NS;

    logic [POWER-1:0] thr_d;
    logic [POWER-1:0] err_d;
    logic             in_v;
    logic             vld_r;

    if (gl == 0) begin : g_src_in
      assign in_v = in_vld;
    end else begin : g_src_prev
      assign in_v = stage_vld[gl-1];
    end

    // Combine SPLIT sub-slices per node: a valid lower sub forces higher subs to all-ones.
    always_comb begin
      logic          any_v;
      logic          any_e;
      int unsigned   nv;
      logic [IW-1:0] base;
      thr_d = '0;
      err_d = '0;
      any_v = 1'b0;
      any_e = 1'b0;
      nv    = 0;
      base  = '0;
      for (int unsigned n = 0; n < NN; n++) begin
        any_v = 1'b0;
        any_e = 1'b0;
        nv    = 0;
        for (int unsigned k = 0; k < SPLIT; k++) begin
          base = IW'(n * NS + k * SS);
          thr_d[base +: SS] = any_v ? {SS{1'b1}} : src_thr[gl][base +: SS];
          any_e = any_e | (|src_err[gl][base +: SS]);
          any_v = any_v | src_thr[gl][base + IW'(SS - 1)];
          nv    = nv + 32'(src_thr[gl][base + IW'(SS - 1)]);
        end
        err_d[n * NS +: NS] = {NS{any_e || (nv > 1)}};
      end
    end

    // Stage valid bit.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_r <= 1'b0;
      end else if (stage_ld[gl]) begin
        vld_r <= in_v;
      end
    end

    assign stage_vld[gl] = vld_r;

    if (gl < int'(LEVELS) - 1) begin : g_mid
      logic [POWER-1:0] thr_r;
      logic [POWER-1:0] err_r;

      // Intermediate partial thermometers and error flags.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          thr_r <= '0;
          err_r <= '0;
        end else if (stage_ld[gl]) begin
          thr_r <= thr_d;
          err_r <= err_d;
        end
      end

      assign src_thr[gl+1] = thr_r;
      assign src_err[gl+1] = err_r;
    end else begin : g_last
      // Root results go straight to the output registers; padding is truncated here.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          dec_vld <= '0;
          enc_vld <= 1'b0;
          enc_err <= 1'b0;
        end else if (stage_ld[gl]) begin
          dec_vld <= thr_d[WIDTH-1:0];
          enc_vld <= |thr_d;
          enc_err <= |err_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_onehot_to_priority_pipe.sv
// Bench for onehot_to_priority_pipe: a 32/2 instance and an 8/4 instance,
// checked against an arithmetic model of the lowest-set-bit thermometer.
module tb_onehot_to_priority_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_enc_vld, a_enc_err;
  logic [31:0] a_dec_oht, a_dec_vld;
  logic        b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_enc_vld, b_enc_err;
  logic [7:0]  b_dec_oht, b_dec_vld;

  int checks = 0;
  int errors = 0;

  onehot_to_priority_pipe #(.WIDTH(32), .SPLIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_vld(a_in_vld), .in_rdy(a_in_rdy), .dec_oht(a_dec_oht),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .dec_vld(a_dec_vld), .enc_vld(a_enc_vld),
    .enc_err(a_enc_err)
  );

  onehot_to_priority_pipe #(.WIDTH(8), .SPLIT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_vld(b_in_vld), .in_rdy(b_in_rdy), .dec_oht(b_dec_oht),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .dec_vld(b_dec_vld), .enc_vld(b_enc_vld),
    .enc_err(b_enc_err)
  );

  // Thermometer of the lowest set bit: isolate it, then invert (bit - 1).
  function automatic logic [31:0] ref_therm(input logic [31:0] x);
    logic [31:0] low;
    if (x == 32'd0) return 32'd0;
    low = x & (~x + 32'd1);
    return ~(low - 32'd1);
  endfunction

  // Random input: one-hot only (mode 0) or a mix with zero and multi-hot (mode 1).
  function automatic logic [31:0] gen_word(input int mode, input int bits);
    int r;
    r = int'($urandom_range(99));
    if (mode == 1 && r < 20) return 32'd0;
    if (mode == 1 && r < 40) return ($urandom() | (32'd1 << $urandom_range(bits - 1)))
                                    & ((bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1));
    return 32'd1 << $urandom_range(bits - 1);
  endfunction

  task automatic drain();
    @(negedge clk);
    a_in_vld = 1'b0; b_in_vld = 1'b0; a_out_rdy = 1'b1; b_out_rdy = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (a_out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", a_out_vld); end
    checks++; if (a_dec_vld !== 32'd0) begin errors++; $display("FAIL reset_dec_vld: got %h expected 0", a_dec_vld); end
    checks++; if ({a_enc_vld, a_enc_err} !== 2'b00) begin errors++; $display("FAIL reset_enc: got %b%b expected 00", a_enc_vld, a_enc_err); end
    checks++; if (a_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b expected 1", a_in_rdy); end
    checks++; if ({b_out_vld, b_in_rdy, b_dec_vld} !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL reset_b: got %b %b %h expected 0 1 00", b_out_vld, b_in_rdy, b_dec_vld); end
  endtask

  task automatic test_basic();
    logic [31:0] xs [2];
    logic [31:0] ed [2];
    logic [1:0]  ef [2];
    int lat;
    xs = '{32'h0000_0010, 32'h0000_0000};
    ed = '{32'hFFFF_FFF0, 32'h0000_0000};
    ef = '{2'b10, 2'b00};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_in_vld = 1'b1; a_dec_oht = xs[i]; a_out_rdy = 1'b1;
      #1;
      checks++; if (a_in_rdy !== 1'b1) begin errors++; $display("FAIL basic_in_rdy[%0d]: got %b expected 1", i, a_in_rdy); end
      @(negedge clk);
      a_in_vld = 1'b0;
      lat = 1;
      while (a_out_vld !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected 5", i, lat); end
      checks++; if ({a_dec_vld, a_enc_vld, a_enc_err} !== {ed[i], ef[i]}) begin errors++; $display("FAIL basic_data[%0d]: got %h %b%b expected %h %b", i, a_dec_vld, a_enc_vld, a_enc_err, ed[i], ef[i]); end
    end
  endtask

  task automatic test_multihot();
    logic [31:0] xs [2];
    logic [31:0] ed [2];
    int lat;
    xs = '{32'h0000_0081, 32'h8000_4000};
    ed = '{32'hFFFF_FFFF, 32'hFFFF_C000};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      a_in_vld = 1'b1; a_dec_oht = xs[i]; a_out_rdy = 1'b1;
      @(negedge clk);
      a_in_vld = 1'b0;
      lat = 1;
      while (a_out_vld !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      checks++; if ({a_dec_vld, a_enc_vld, a_enc_err} !== {ed[i], 2'b11}) begin errors++; $display("FAIL multihot[%0d]: got %h %b%b expected %h 11", i, a_dec_vld, a_enc_vld, a_enc_err, ed[i]); end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int got = 0;
    int cyc = 0;
    logic [31:0] e;
    @(negedge clk);
    a_out_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) @(negedge clk);
      a_in_vld = 1'b1; a_dec_oht = 32'd1 << idx;
      #1;
      if (a_in_rdy) idx++;
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", idx); end
    checks++; if (a_in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy: got %b expected 0", a_in_rdy); end
    while (got < 32 && cyc < 200) begin
      @(negedge clk);
      a_out_rdy = 1'b1;
      a_in_vld = (idx < 32);
      a_dec_oht = 32'd1 << idx;
      #1;
      if (a_in_vld && a_in_rdy) idx++;
      if (a_out_vld) begin
        e = ~((32'd1 << got) - 32'd1);
        checks++; if ({a_dec_vld, a_enc_vld, a_enc_err} !== {e, 2'b10}) begin errors++; $display("FAIL bp_out[%0d]: got %h %b%b expected %h 10", got, a_dec_vld, a_enc_vld, a_enc_err, e); end
        got++;
      end
      cyc++;
    end
    checks++; if (got != 32) begin errors++; $display("FAIL bp_count: got %0d expected 32", got); end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1, stall = 0;
    logic [31:0] e;
    for (int c = 0; c < 40 && got < 20; c++) begin
      @(negedge clk);
      a_out_rdy = 1'b1;
      a_in_vld = (sent < 20);
      a_dec_oht = 32'd1 << sent;
      #1;
      if (a_in_vld && !a_in_rdy) stall++;
      if (a_in_vld && a_in_rdy) sent++;
      if (a_out_vld) begin
        if (first < 0) first = c;
        last = c;
        e = ~((32'd1 << got) - 32'd1);
        checks++; if (a_dec_vld !== e) begin errors++; $display("FAIL b2b_out[%0d]: got %h expected %h", got, a_dec_vld, e); end
        got++;
      end
    end
    checks++; if (stall != 0) begin errors++; $display("FAIL b2b_stall: got %0d expected 0", stall); end
    checks++; if (first != 5) begin errors++; $display("FAIL b2b_first: got %0d expected 5", first); end
    checks++; if (got != 20 || last - first != 19) begin errors++; $display("FAIL b2b_span: got %0d words over %0d cycles expected 20 over 19", got, last - first); end
  endtask

  task automatic test_random_a(input int n);
    logic [31:0] q[$];
    logic [31:0] x, e;
    int sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 20000) begin
      @(negedge clk);
      a_in_vld  = (sent < n) && ($urandom_range(99) < 70);
      a_dec_oht = gen_word(1, 32);
      a_out_rdy = ($urandom_range(99) < 60);
      #1;
      if (a_in_vld && a_in_rdy) begin q.push_back(a_dec_oht); sent++; end
      if (a_out_vld && a_out_rdy) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rand_a_spurious: got %h expected no output", a_dec_vld);
        end else begin
          x = q.pop_front();
          e = ref_therm(x);
          checks++;
          if ({a_dec_vld, a_enc_vld, a_enc_err} !== {e, (x != 32'd0), ($countones(x) > 1)}) begin
            errors++; $display("FAIL rand_a[%0d]: in %h got %h %b%b expected %h", got, x, a_dec_vld, a_enc_vld, a_enc_err, e);
          end
          if ($countones(x) == 1) begin
            checks++;
            if ((a_dec_vld & ~(a_dec_vld << 1)) !== x) begin errors++; $display("FAIL rand_a_roundtrip[%0d]: got %h expected %h", got, a_dec_vld & ~(a_dec_vld << 1), x); end
          end
        end
        got++;
      end
      cyc++;
    end
    checks++; if (got != n) begin errors++; $display("FAIL rand_a_count: got %0d expected %0d", got, n); end
  endtask

  task automatic test_reset_midstream();
    int seen = 0, lat;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_out_rdy = 1'b0; a_in_vld = 1'b1; a_dec_oht = 32'd1 << (i * 5 + 1);
      #1;
      checks++; if (a_in_rdy !== 1'b1) begin errors++; $display("FAIL mid_fill[%0d]: got %b expected 1", i, a_in_rdy); end
    end
    @(negedge clk);
    rst_n = 1'b0; a_in_vld = 1'b1; a_dec_oht = 32'h0000_0100; a_out_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; a_in_vld = 1'b0;
    #1;
    checks++; if ({a_out_vld, a_in_rdy} !== 2'b01) begin errors++; $display("FAIL mid_release: got vld %b rdy %b expected 0 1", a_out_vld, a_in_rdy); end
    repeat (8) begin @(negedge clk); if (a_out_vld) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL mid_discard: got %0d outputs expected 0", seen); end
    @(negedge clk);
    a_in_vld = 1'b1; a_dec_oht = 32'h0004_0000;
    @(negedge clk);
    a_in_vld = 1'b0;
    lat = 1;
    while (a_out_vld !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 5) begin errors++; $display("FAIL mid_latency: got %0d expected 5", lat); end
    checks++; if (a_dec_vld !== 32'hFFFC_0000) begin errors++; $display("FAIL mid_data: got %h expected fffc0000", a_dec_vld); end
  endtask

  task automatic test_zero_ext_b(input int n);
    logic [7:0]  q[$];
    logic [7:0]  x, e;
    logic [31:0] e32;
    int lat, sent = 0, got = 0, cyc = 0;
    @(negedge clk);
    b_in_vld = 1'b1; b_dec_oht = 8'h80; b_out_rdy = 1'b1;
    @(negedge clk);
    b_in_vld = 1'b0;
    lat = 1;
    while (b_out_vld !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat != 2) begin errors++; $display("FAIL zext_latency: got %0d expected 2", lat); end
    checks++; if ({b_dec_vld, b_enc_vld, b_enc_err} !== {8'h80, 2'b10}) begin errors++; $display("FAIL zext_data: got %h %b%b expected 80 10", b_dec_vld, b_enc_vld, b_enc_err); end
    while (got < n && cyc < 5000) begin
      @(negedge clk);
      b_in_vld  = (sent < n) && ($urandom_range(99) < 70);
      b_dec_oht = 8'(gen_word(1, 8));
      b_out_rdy = ($urandom_range(99) < 60);
      #1;
      if (b_in_vld && b_in_rdy) begin q.push_back(b_dec_oht); sent++; end
      if (b_out_vld && b_out_rdy && q.size() != 0) begin
        x = q.pop_front();
        e32 = ref_therm({24'd0, x});
        e = e32[7:0];
        checks++;
        if ({b_dec_vld, b_enc_vld, b_enc_err} !== {e, (x != 8'd0), ($countones(x) > 1)}) begin
          errors++; $display("FAIL rand_b[%0d]: in %h got %h %b%b expected %h", got, x, b_dec_vld, b_enc_vld, b_enc_err, e);
        end
        if ($countones(x) == 1) begin
          checks++;
          if ((b_dec_vld & ~(b_dec_vld << 1)) !== x) begin errors++; $display("FAIL rand_b_roundtrip[%0d]: got %h expected %h", got, b_dec_vld & ~(b_dec_vld << 1), x); end
        end
        got++;
      end
      cyc++;
    end
    checks++; if (got != n) begin errors++; $display("FAIL rand_b_count: got %0d expected %0d", got, n); end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_vld = 1'b0; a_dec_oht = '0; a_out_rdy = 1'b1;
    b_in_vld = 1'b0; b_dec_oht = '0; b_out_rdy = 1'b1;
    test_reset();
    test_basic();
    drain();
    test_multihot();
    drain();
    test_backpressure();
    drain();
    test_back_to_back();
    drain();
    test_random_a(300);
    drain();
    test_reset_midstream();
    drain();
    test_zero_ext_b(150);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
